// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue sequencer: op classes, ALU control
// codes, funct3 values, decode select types and the sequencer state type.
package alu_defs;

    typedef enum logic [2:0] {
        CLS_OP      = 3'd0,
        CLS_OP_IMM  = 3'd1,
        CLS_LUI     = 3'd2,
        CLS_AUIPC   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_JALR    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_cls_e;

    // ctr[3] selects the signed Less comparison in the ALU
    localparam logic [3:0] CTR_ADD   = 4'b0000;
    localparam logic [3:0] CTR_SUB   = 4'b1000;
    localparam logic [3:0] CTR_SLL   = 4'b0001;
    localparam logic [3:0] CTR_SLTU  = 4'b0010;
    localparam logic [3:0] CTR_SLT   = 4'b1010;
    localparam logic [3:0] CTR_PASSB = 4'b0011;
    localparam logic [3:0] CTR_XOR   = 4'b0100;
    localparam logic [3:0] CTR_SRL   = 4'b0101;
    localparam logic [3:0] CTR_SRA   = 4'b1101;
    localparam logic [3:0] CTR_OR    = 4'b0110;
    localparam logic [3:0] CTR_AND   = 4'b0111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {A_RS1, A_PC} a_sel_e;
    typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_e;
    typedef enum logic [1:0] {FLOW_SEQ, FLOW_BRANCH, FLOW_JAL, FLOW_JALR} flow_e;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;

    // Register/immediate ALU op map; alt selects SUB at 000 and SRA at 101
    function automatic logic [3:0] alu_op_ctr(input logic [2:0] funct3, input logic alt);
        logic [3:0] ctr;
        case (funct3)
            F3_ADD:  ctr = alt ? CTR_SUB : CTR_ADD;
            F3_SLL:  ctr = CTR_SLL;
            F3_SLT:  ctr = CTR_SLT;
            F3_SLTU: ctr = CTR_SLTU;
            F3_XOR:  ctr = CTR_XOR;
            F3_SR:   ctr = alt ? CTR_SRA : CTR_SRL;
            F3_OR:   ctr = CTR_OR;
            default: ctr = CTR_AND;
        endcase
        return ctr;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational decode of op class / funct3 / bit 30 into ALU control,
// operand selects, control-flow kind, branch test and illegal flag.
module alu_ctr_decode
    import alu_defs::*;
(
    input  logic [2:0] cls_i,
    input  logic [2:0] funct3_i,
    input  logic       f7b5_i,
    output logic [3:0] ctr_o,
    output a_sel_e     a_sel_o,
    output b_sel_e     b_sel_o,
    output flow_e      flow_o,
    output logic       test_zero_o,
    output logic       test_inv_o,
    output logic       illegal_o
);

    // Per-class decode; illegal encodings leave flow sequential
    always_comb begin
        ctr_o       = CTR_ADD;
        a_sel_o     = A_RS1;
        b_sel_o     = B_RS2;
        flow_o      = FLOW_SEQ;
        test_zero_o = 1'b0;
        test_inv_o  = 1'b0;
        illegal_o   = 1'b0;
        case (op_cls_e'(cls_i))
            CLS_OP: begin
                ctr_o     = alu_op_ctr(funct3_i, f7b5_i);
                illegal_o = f7b5_i && (funct3_i != F3_ADD) && (funct3_i != F3_SR);
            end
            CLS_OP_IMM: begin
                b_sel_o = B_IMM;
                ctr_o   = alu_op_ctr(funct3_i, f7b5_i && (funct3_i == F3_SR));
            end
            CLS_LUI: begin
                b_sel_o = B_IMM;
                ctr_o   = CTR_PASSB;
            end
            CLS_AUIPC: begin
                a_sel_o = A_PC;
                b_sel_o = B_IMM;
            end
            CLS_BRANCH: begin
                flow_o     = FLOW_BRANCH;
                // BNE/BGE/BGEU are the odd funct3 values: invert the test
                test_inv_o = funct3_i[0];
                case (funct3_i)
                    F3_BEQ, F3_BNE: begin
                        ctr_o       = CTR_SUB;
                        test_zero_o = 1'b1;
                    end
                    F3_BLT, F3_BGE:   ctr_o = CTR_SLT;
                    F3_BLTU, F3_BGEU: ctr_o = CTR_SLTU;
                    default: begin
                        illegal_o = 1'b1;
                        flow_o    = FLOW_SEQ;
                    end
                endcase
            end
            CLS_JAL: begin
                a_sel_o = A_PC;
                b_sel_o = B_FOUR;
                flow_o  = FLOW_JAL;
            end
            CLS_JALR: begin
                a_sel_o = A_PC;
                b_sel_o = B_FOUR;
                flow_o  = FLOW_JALR;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: accepts a decoded op, drives the external ALU from
// registered operands, captures its result and presents rd / next PC.
module alu_issue_ctrl
    import alu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_cls,
    input  logic [2:0]  in_funct3,
    input  logic        in_f7b5,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    input  logic [31:0] alu_out,
    input  logic        alu_less,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [31:0] res_next_pc,
    output logic        res_taken,
    output logic        res_illegal
);

    state_e      state_q, state_d;
    logic        accept;

    logic [3:0]  dec_ctr;
    a_sel_e      dec_a_sel;
    b_sel_e      dec_b_sel;
    flow_e       dec_flow;
    logic        dec_test_zero, dec_test_inv, dec_illegal;

    logic [31:0] opa_d, opb_d, target_sum, target_d, pc4_d;
    logic [31:0] alu_a_q, alu_b_q, target_q, pc4_q;
    logic [3:0]  alu_ctr_q;
    flow_e       flow_q;
    logic        test_zero_q, test_inv_q, illegal_q;

    logic [31:0] res_data_d, res_next_pc_d, res_data_q, res_next_pc_q;
    logic        res_taken_d, res_taken_q, res_illegal_q, cond;

    alu_ctr_decode u_decode (
        .cls_i       (in_cls),
        .funct3_i    (in_funct3),
        .f7b5_i      (in_f7b5),
        .ctr_o       (dec_ctr),
        .a_sel_o     (dec_a_sel),
        .b_sel_o     (dec_b_sel),
        .flow_o      (dec_flow),
        .test_zero_o (dec_test_zero),
        .test_inv_o  (dec_test_inv),
        .illegal_o   (dec_illegal)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: DONE with res_ready can take the next op straight into EXEC
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: if (res_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready);
        res_valid = (state_q == ST_DONE);
        accept    = in_valid && in_ready;
    end

    // Operand selection and the dedicated target / pc+4 adders
    always_comb begin
        opa_d      = (dec_a_sel == A_PC) ? in_pc : in_rs1;
        case (dec_b_sel)
            B_IMM:   opb_d = in_imm;
            B_FOUR:  opb_d = 32'd4;
            default: opb_d = in_rs2;
        endcase
        target_sum = ((dec_flow == FLOW_JALR) ? in_rs1 : in_pc) + in_imm;
        target_d   = {target_sum[31:1], target_sum[0] & (dec_flow != FLOW_JALR)};
        pc4_d      = in_pc + 32'd4;
    end

    // Operand / control registers loaded on each accepted op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctr_q   <= CTR_ADD;
            target_q    <= '0;
            pc4_q       <= '0;
            flow_q      <= FLOW_SEQ;
            test_zero_q <= 1'b0;
            test_inv_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            alu_a_q     <= opa_d;
            alu_b_q     <= opb_d;
            alu_ctr_q   <= dec_ctr;
            target_q    <= target_d;
            pc4_q       <= pc4_d;
            flow_q      <= dec_flow;
            test_zero_q <= dec_test_zero;
            test_inv_q  <= dec_test_inv;
            illegal_q   <= dec_illegal;
        end
    end

    // Result formation from the ALU response
    always_comb begin
        cond          = test_zero_q ? alu_zero : alu_less;
        res_taken_d   = !illegal_q && ((flow_q == FLOW_JAL) || (flow_q == FLOW_JALR) ||
                                       ((flow_q == FLOW_BRANCH) && (cond ^ test_inv_q)));
        res_data_d    = (illegal_q || (flow_q == FLOW_BRANCH)) ? '0 : alu_out;
        res_next_pc_d = res_taken_d ? target_q : pc4_q;
    end

    // Result capture; only EXEC writes, so results hold through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data_q    <= '0;
            res_next_pc_q <= '0;
            res_taken_q   <= 1'b0;
            res_illegal_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            res_data_q    <= res_data_d;
            res_next_pc_q <= res_next_pc_d;
            res_taken_q   <= res_taken_d;
            res_illegal_q <= illegal_q;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctr     = alu_ctr_q;
    assign res_data    = res_data_q;
    assign res_next_pc = res_next_pc_q;
    assign res_taken   = res_taken_q;
    assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, RV32I-level reference model,
// directed cases followed by randomized ops with random back-pressure.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1, rs2, imm, pc;
    } op_t;

    typedef struct {
        logic [31:0] data, npc;
        logic        taken, ill, ctr_known;
        logic [3:0]  ctr;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_ready, in_f7b5;
    logic [2:0]  in_cls, in_funct3;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctr;
    logic        alu_less, alu_zero;
    logic        res_valid, res_ready, res_taken, res_illegal;
    logic [31:0] res_data, res_next_pc;

    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b5(in_f7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_out(alu_out), .alu_less(alu_less), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_next_pc(res_next_pc),
        .res_taken(res_taken), .res_illegal(res_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        alu_less = alu_ctr[3] ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);
        case (alu_ctr)
            4'b0000: alu_out = alu_a + alu_b;
            4'b1000: alu_out = alu_a - alu_b;
            4'b0001: alu_out = alu_a << alu_b[4:0];
            4'b0010, 4'b1010: alu_out = {31'd0, alu_less};
            4'b0011: alu_out = alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = alu_a >> alu_b[4:0];
            4'b1101: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b0110: alu_out = alu_a | alu_b;
            4'b0111: alu_out = alu_a & alu_b;
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    // Reference model in RV32I instruction terms
    function automatic exp_t model(input op_t o);
        exp_t        e;
        logic [31:0] b;
        logic        c;
        e.data = 32'd0; e.npc = o.pc + 32'd4; e.taken = 1'b0; e.ill = 1'b0;
        e.ctr_known = 1'b1; e.ctr = 4'b0000;
        case (o.cls)
            3'd0, 3'd1: begin
                b = (o.cls == 3'd0) ? o.rs2 : o.imm;
                if (o.cls == 3'd0 && o.f7 && o.f3 != 3'd0 && o.f3 != 3'd5) e.ill = 1'b1;
                else case (o.f3)
                    3'd0: if (o.cls == 3'd0 && o.f7) begin e.data = o.rs1 - b; e.ctr = 4'b1000; end
                          else begin e.data = o.rs1 + b; e.ctr = 4'b0000; end
                    3'd1: begin e.data = o.rs1 << b[4:0]; e.ctr = 4'b0001; end
                    3'd2: begin e.data = ($signed(o.rs1) < $signed(b)) ? 32'd1 : 32'd0; e.ctr = 4'b1010; end
                    3'd3: begin e.data = (o.rs1 < b) ? 32'd1 : 32'd0; e.ctr = 4'b0010; end
                    3'd4: begin e.data = o.rs1 ^ b; e.ctr = 4'b0100; end
                    3'd5: if (o.f7) begin e.data = $unsigned($signed(o.rs1) >>> b[4:0]); e.ctr = 4'b1101; end
                          else begin e.data = o.rs1 >> b[4:0]; e.ctr = 4'b0101; end
                    3'd6: begin e.data = o.rs1 | b; e.ctr = 4'b0110; end
                    default: begin e.data = o.rs1 & b; e.ctr = 4'b0111; end
                endcase
            end
            3'd2: begin e.data = o.imm; e.ctr = 4'b0011; end
            3'd3: e.data = o.pc + o.imm;
            3'd4: begin
                c = 1'b0;
                case (o.f3)
                    3'd0: begin c = (o.rs1 == o.rs2); e.ctr = 4'b1000; end
                    3'd1: begin c = (o.rs1 != o.rs2); e.ctr = 4'b1000; end
                    3'd4: begin c = ($signed(o.rs1) < $signed(o.rs2)); e.ctr = 4'b1010; end
                    3'd5: begin c = ($signed(o.rs1) >= $signed(o.rs2)); e.ctr = 4'b1010; end
                    3'd6: begin c = (o.rs1 < o.rs2); e.ctr = 4'b0010; end
                    3'd7: begin c = (o.rs1 >= o.rs2); e.ctr = 4'b0010; end
                    default: e.ill = 1'b1;
                endcase
                e.taken = c;
                if (c) e.npc = o.pc + o.imm;
            end
            3'd5: begin e.data = o.pc + 32'd4; e.taken = 1'b1; e.npc = o.pc + o.imm; end
            3'd6: begin e.data = o.pc + 32'd4; e.taken = 1'b1; e.npc = (o.rs1 + o.imm) & 32'hFFFF_FFFE; end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.data = 32'd0; e.npc = o.pc + 32'd4; e.taken = 1'b0; e.ctr_known = 1'b0;
        end
        return e;
    endfunction

    function automatic op_t mk(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc);
        op_t o;
        o.cls = cls; o.f3 = f3; o.f7 = f7; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm; o.pc = pc;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t         o;
        logic [31:0] r;
        o.cls = 3'($urandom_range(0, 7));
        o.f3  = 3'($urandom_range(0, 7));
        o.f7  = ($urandom_range(0, 3) == 0);
        o.rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        o.rs2 = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
        r     = $urandom;
        o.imm = (o.cls == 3'd2 || o.cls == 3'd3) ? {r[31:12], 12'd0} : {{20{r[11]}}, r[11:0]};
        r     = $urandom;
        o.pc  = {r[31:2], 2'b00};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input op_t o);
        in_cls = o.cls; in_funct3 = o.f3; in_f7b5 = o.f7;
        in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm; in_pc = o.pc;
    endtask

    task automatic check_res(input string tag, input exp_t e);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_data"}, res_data, e.data);
        chk({tag, "_npc"}, res_next_pc, e.npc);
        chk({tag, "_taken"}, {31'd0, res_taken}, {31'd0, e.taken});
        chk({tag, "_ill"}, {31'd0, res_illegal}, {31'd0, e.ill});
    endtask

    // Called #1 after the accept edge: result must appear one edge later
    task automatic post_accept(input string tag, input exp_t e);
        if (e.ctr_known) chk({tag, "_ctr"}, {28'd0, alu_ctr}, {28'd0, e.ctr});
        chk({tag, "_exec_novalid"}, {31'd0, res_valid}, 32'd0);
        @(posedge clk); #1;
        check_res(tag, e);
    endtask

    task automatic issue(input string tag, input op_t o);
        @(negedge clk);
        drive(o);
        in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        post_accept(tag, model(o));
    endtask

    task automatic release_res();
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    // Issue, hold the result for 'stall' cycles with unrelated traffic, release
    task automatic run_op(input string tag, input op_t o, input int unsigned stall);
        exp_t e;
        e = model(o);
        issue(tag, o);
        for (int unsigned i = 0; i < stall; i++) begin
            @(negedge clk);
            drive(rand_op());
            in_valid = 1'b1;
            #1 chk({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk({tag, "_hold_data"}, res_data, e.data);
            chk({tag, "_hold_npc"}, res_next_pc, e.npc);
        end
        release_res();
    endtask

    initial begin
        op_t  o1, o2;
        exp_t e1, e2;

        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        drive(mk(3'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0));
        #12;
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_data", res_data, 32'd0);
        chk("rst_npc", res_next_pc, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_ctr", {28'd0, alu_ctr}, 32'd0);
        chk("rst_taken", {31'd0, res_taken}, 32'd0);
        chk("rst_ill", {31'd0, res_illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", mk(3'd0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h100), 0);
        chk("add_lit", res_data, 32'd12);
        chk("add_lit_npc", res_next_pc, 32'h104);
        run_op("sub", mk(3'd0, 3'd0, 1'b1, 32'd0, 32'd1, 32'd0, 32'h200), 1);
        chk("sub_lit", res_data, 32'hFFFF_FFFF);
        run_op("slt", mk(3'd0, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0), 0);
        chk("slt_lit", res_data, 32'd1);
        run_op("sltu", mk(3'd0, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h0), 0);
        chk("sltu_lit", res_data, 32'd0);
        run_op("blt", mk(3'd4, 3'd4, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'h10, 32'h8000_0000), 0);
        chk("blt_lit_taken", {31'd0, res_taken}, 32'd1);
        chk("blt_lit_npc", res_next_pc, 32'h8000_0010);
        run_op("bgeu", mk(3'd4, 3'd7, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'h10, 32'h8000_0000), 0);
        chk("bgeu_lit_taken", {31'd0, res_taken}, 32'd1);
        run_op("jalr", mk(3'd6, 3'd0, 1'b0, 32'h8000_0103, 32'd0, 32'd2, 32'h8000_0000), 0);
        chk("jalr_lit_npc", res_next_pc, 32'h8000_0104);
        chk("jalr_lit_data", res_data, 32'h8000_0004);
        run_op("sll_f7", mk(3'd0, 3'd1, 1'b1, 32'd3, 32'd1, 32'd0, 32'h40), 0);
        chk("sll_f7_lit_ill", {31'd0, res_illegal}, 32'd1);
        run_op("cls7", mk(3'd7, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'h80), 0);

        // Back-pressure then direct hand-over of the held op from DONE
        o1 = mk(3'd1, 3'd4, 1'b0, 32'h0F0F_0F0F, 32'd0, 32'hFFFF_FFFF, 32'h300);
        o2 = mk(3'd5, 3'd0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h400);
        e1 = model(o1);
        e2 = model(o2);
        issue("bp1", o1);
        @(negedge clk);
        drive(o2);
        in_valid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_data", res_data, e1.data);
            chk("bp_npc", res_next_pc, e1.npc);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        post_accept("bp2", e2);
        release_res();

        // Reset while the op is in EXEC
        @(negedge clk);
        drive(mk(3'd0, 3'd0, 1'b0, 32'd9, 32'd9, 32'd0, 32'h500));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_exec_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_exec_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_exec_ctr", {28'd0, alu_ctr}, 32'd0);
        chk("rst_exec_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_after_valid", {31'd0, res_valid}, 32'd0);
            chk("rst_after_ready", {31'd0, in_ready}, 32'd1);
        end

        for (int unsigned n = 0; n < 150; n++)
            run_op("rand", rand_op(), 32'($urandom_range(0, 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
